// File: rtl/latch_seq_pkg.sv
// Shared encodings and counter sizing for the latch write sequencer.
// Phase lengths are 1..15 cycles, so a 4-bit down-counter holding length-1 suffices.
package latch_seq_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] OPEN  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_SETUP = SETUP,
        ST_OPEN  = OPEN,
        ST_HOLD  = HOLD
    } state_e;

    typedef logic [CNT_W-1:0] cnt_t;

    // Counter load value for a phase of `len` cycles.
    function automatic cnt_t phase_load(input int unsigned len);
        return cnt_t'(len - 1);
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable phase down-counter; holds at zero and flags it.
module phase_counter
    import latch_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  cnt_t load_val,
    output cnt_t value,
    output logic zero
);

    cnt_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - cnt_t'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/latch_write_sequencer.sv
// Drives a transparent latch bank: present D, pulse En for a fixed window,
// hold D afterwards, then report completion and count finished writes.
module latch_write_sequencer
    import latch_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned OPEN_CYC  = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] D,
    output logic             En,
    output logic             done,
    output logic [7:0]       wr_count
);

    localparam cnt_t SETUP_LD = phase_load(SETUP_CYC);
    localparam cnt_t OPEN_LD  = phase_load(OPEN_CYC);
    localparam cnt_t HOLD_LD  = phase_load(HOLD_CYC);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] d_q;
    logic             en_q;
    logic [7:0]       wr_count_q;

    logic cnt_load;
    cnt_t cnt_load_val;
    cnt_t cnt_val;
    logic cnt_zero;
    logic accept;

    phase_counter u_phase_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .value    (cnt_val),
        .zero     (cnt_zero)
    );

    assign din_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = din_valid && din_ready;

    // Every transition reloads the counter with the length of the phase being entered.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d      = ST_SETUP;
                    cnt_load     = 1'b1;
                    cnt_load_val = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d      = ST_OPEN;
                    cnt_load     = 1'b1;
                    cnt_load_val = OPEN_LD;
                end
            end
            ST_OPEN: begin
                if (cnt_zero) begin
                    state_d      = ST_HOLD;
                    cnt_load     = 1'b1;
                    cnt_load_val = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d  = ST_IDLE;
                    cnt_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign done = (state_q == ST_HOLD) && (cnt_val == '0);

    // En is decoded from next state so it is a clean flop output aligned with OPEN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            d_q        <= '0;
            en_q       <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= (state_d == ST_OPEN);
            if (accept)
                d_q <= din;
            if (done)
                wr_count_q <= wr_count_q + 8'd1;
        end
    end

    assign D        = d_q;
    assign En       = en_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Directed checks: a vector table for the default timing, plus hand sequences
// for wr_count wrap and non-default phase lengths.
module tb_latch_write_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;

    logic       din_ready, en, done;
    logic [7:0] d, wr_count;
    logic       din_ready2, en2, done2;
    logic [7:0] d2, wr_count2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    latch_write_sequencer u_dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .D         (d),
        .En        (en),
        .done      (done),
        .wr_count  (wr_count)
    );

    latch_write_sequencer #(
        .WIDTH     (8),
        .SETUP_CYC (3),
        .OPEN_CYC  (1),
        .HOLD_CYC  (2)
    ) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready2),
        .D         (d2),
        .En        (en2),
        .done      (done2),
        .wr_count  (wr_count2)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] din;
        logic       rdy;
        logic [7:0] d;
        logic       en;
        logic       dn;
        logic [7:0] wc;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        din_valid = 1'b0;
        din = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // rst, vld, din   | rdy, D, En, done, wr_count (observed during the same cycle)
        vecs[0]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 8'hA5, 1'b1, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 8'hA5, 1'b1, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1, 8'd0};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 8'd1};
        vecs[7]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'hA5, 1'b0, 1'b0, 8'd1};
        vecs[8]  = '{1'b0, 1'b1, 8'h11, 1'b0, 8'h11, 1'b0, 1'b0, 8'd1};
        vecs[9]  = '{1'b0, 1'b1, 8'h22, 1'b0, 8'h11, 1'b1, 1'b0, 8'd1};
        vecs[10] = '{1'b0, 1'b1, 8'h22, 1'b0, 8'h11, 1'b1, 1'b0, 8'd1};
        vecs[11] = '{1'b0, 1'b1, 8'h22, 1'b0, 8'h11, 1'b0, 1'b1, 8'd1};
        vecs[12] = '{1'b0, 1'b1, 8'h22, 1'b1, 8'h11, 1'b0, 1'b0, 8'd2};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h22, 1'b0, 1'b0, 8'd2};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h22, 1'b1, 1'b0, 8'd2};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0};
        vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0};

        repeat (2) @(posedge clk);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            din_valid = vecs[i].vld;
            din       = vecs[i].din;
            #1;
            chk($sformatf("row%0d din_ready", i), 32'(din_ready), 32'(vecs[i].rdy));
            chk($sformatf("row%0d D", i),         32'(d),         32'(vecs[i].d));
            chk($sformatf("row%0d En", i),        32'(en),        32'(vecs[i].en));
            chk($sformatf("row%0d done", i),      32'(done),      32'(vecs[i].dn));
            chk($sformatf("row%0d wr_count", i),  32'(wr_count),  32'(vecs[i].wc));
        end

        // 256 back-to-back writes: wr_count follows the done count and wraps to 0.
        begin
            int dones = 0;
            int cyc = 0;
            do_reset();
            din_valid = 1'b1;
            din = 8'h3C;
            while (dones < 256 && cyc < 4000) begin
                @(negedge clk);
                #1;
                cyc++;
                if (done) begin
                    dones++;
                    if (dones == 256) din_valid = 1'b0;
                    @(negedge clk);
                    #1;
                    cyc++;
                    chk($sformatf("wrap wr_count after %0d", dones), 32'(wr_count), 32'(dones % 256));
                end
            end
            chk("wrap done pulses", 32'(dones), 32'd256);
            @(negedge clk);
            #1;
            chk("wrap idle ready", 32'(din_ready), 32'd1);
            chk("wrap final D", 32'(d), 32'h3C);
        end

        // Non-default phase lengths: SETUP 3, OPEN 1, HOLD 2.
        do_reset();
        din_valid = 1'b1;
        din = 8'h5A;
        #1;
        chk("p2 ready at accept", 32'(din_ready2), 32'd1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            din_valid = 1'b0;
            #1;
            chk($sformatf("p2 c%0d En", c),   32'(en2),        32'(c == 4));
            chk($sformatf("p2 c%0d done", c), 32'(done2),      32'(c == 6));
            chk($sformatf("p2 c%0d ready", c), 32'(din_ready2), 32'(c >= 7));
            chk($sformatf("p2 c%0d D", c),    32'(d2),         32'h5A);
        end
        chk("p2 wr_count", 32'(wr_count2), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
